// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for the serial system bus.
// Issues mutually exclusive grants, drives the bus mux select, and supports
// one outstanding split read: the split master is parked, the bus is freed
// for the other master, and ownership returns when the split slave is ready.
//
// Ports:
//   clk, rstn            bus clock, asynchronous active-low reset
//   breq1, breq2         bus requests from master ports 1 and 2
//   bgrant1, bgrant2     grants to masters 1 and 2
//   split1, split2       parked indication to masters 1 and 2
//   msel                 bus mux select (0 = master 1, 1 = master 2)
//   bus_busy             high while either grant is asserted
//   split_req            slave split request (pulse during owner's read)
//   split_ready          split slave ready to return data (pulse or level)
//   split_err            one-cycle pulse when a split_req is ignored
module bus_arbiter #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic breq1,
    input  logic breq2,
    output logic bgrant1,
    output logic bgrant2,
    output logic split1,
    output logic split2,
    output logic msel,
    output logic bus_busy,
    input  logic split_req,
    input  logic split_ready,
    output logic split_err
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        SPLIT_FREE = 2'd2,
        SPLIT_BUSY = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   split_owner, split_owner_nxt;
    logic   last_owner, last_owner_nxt;
    logic   resume_pend, resume_pend_nxt;
    logic   err_q, err_nxt;

    logic   own_req, oth_req, free_req, sreq, srdy;

    // Split inputs are masked off entirely when split handling is disabled
    assign sreq     = SPLIT_EN && split_req;
    assign srdy     = SPLIT_EN && split_ready;
    assign own_req  = owner ? breq2 : breq1;
    assign oth_req  = owner ? breq1 : breq2;
    // Request of the master that is not parked
    assign free_req = split_owner ? breq1 : breq2;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            owner       <= 1'b0;
            split_owner <= 1'b0;
            last_owner  <= 1'b1;
            resume_pend <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            split_owner <= split_owner_nxt;
            last_owner  <= last_owner_nxt;
            resume_pend <= resume_pend_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        split_owner_nxt = split_owner;
        last_owner_nxt  = last_owner;
        resume_pend_nxt = resume_pend;
        // A split is accepted only from a bus owner that is still requesting
        err_nxt         = sreq && !(state == BUSY && own_req);

        case (state)
            IDLE: begin
                if (breq1 && breq2) begin
                    state_nxt      = BUSY;
                    owner_nxt      = ~last_owner;
                    last_owner_nxt = ~last_owner;
                end else if (breq1) begin
                    state_nxt      = BUSY;
                    owner_nxt      = 1'b0;
                    last_owner_nxt = 1'b0;
                end else if (breq2) begin
                    state_nxt      = BUSY;
                    owner_nxt      = 1'b1;
                    last_owner_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (own_req && sreq) begin
                    split_owner_nxt = owner;
                    resume_pend_nxt = srdy;
                    if (oth_req) begin
                        state_nxt      = SPLIT_BUSY;
                        owner_nxt      = ~owner;
                        last_owner_nxt = ~owner;
                    end else begin
                        state_nxt = SPLIT_FREE;
                    end
                end else if (!own_req) begin
                    // Direct handover without an idle gap cycle
                    if (oth_req) begin
                        owner_nxt = ~owner;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SPLIT_FREE: begin
                if (srdy || resume_pend) begin
                    state_nxt       = BUSY;
                    owner_nxt       = split_owner;
                    resume_pend_nxt = 1'b0;
                end else if (free_req) begin
                    state_nxt = SPLIT_BUSY;
                    owner_nxt = ~split_owner;
                end
            end
            SPLIT_BUSY: begin
                if (!own_req) begin
                    if (resume_pend || srdy) begin
                        state_nxt       = BUSY;
                        owner_nxt       = split_owner;
                        resume_pend_nxt = 1'b0;
                    end else begin
                        state_nxt = SPLIT_FREE;
                    end
                end else if (srdy) begin
                    resume_pend_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        bgrant1   = 1'b0;
        bgrant2   = 1'b0;
        split1    = 1'b0;
        split2    = 1'b0;
        msel      = owner;
        split_err = err_q;
        if (state == BUSY || state == SPLIT_BUSY) begin
            bgrant1 = ~owner;
            bgrant2 = owner;
        end
        if (state == SPLIT_FREE || state == SPLIT_BUSY) begin
            split1 = ~split_owner;
            split2 = split_owner;
        end
        bus_busy = bgrant1 | bgrant2;
    end

endmodule
